ram_port_ctrl: RTL and testbench

Single-port RAM controller with a 512 x 9-bit storage array, a valid/ready request port and a valid/ready response port. It sits directly upstream of the design's 9-bit enable-gated capture registers: its response port supplies the data word plus a one-cycle load strobe that those registers consume. It also provides a hardware clear sweep that zero-fills the whole array.

---
 rtl/ram_port_ctrl_pkg.sv | 10 +
 rtl/ram_port_ctrl_if.sv | 26 ++
 rtl/ram_port_ctrl_array.sv | 36 +++
 rtl/ram_port_ctrl.sv | 83 ++++++++
 tb/tb_ram_port_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_ctrl_pkg.sv
// Shared widths, depth and FSM state encoding for the RAM port controller.
package ram_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RD, RESP, CLEAR} ram_state_t;

endpackage

// File: rtl/ram_port_ctrl_if.sv
// Request/response/clear bundle between a requester (master) and the RAM controller (slave).
interface ram_port_ctrl_if;
  import ram_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clr_start;
  logic              clr_busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, clr_start,
    input  req_ready, rsp_valid, rsp_rdata, clr_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, clr_start,
    output req_ready, rsp_valid, rsp_rdata, clr_busy
  );

endinterface

// File: rtl/ram_port_ctrl_array.sv
// DEPTH x DATA_W storage: synchronous write, enable-gated registered read.
module ram_array
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage itself is never reset so a partially cleared array keeps its contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register doubles as the response data word and holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_port_ctrl.sv
// Single-port RAM controller: valid/ready reads and writes plus a full-array zero-fill sweep.
module ram_port_ctrl
  import ram_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  ram_port_ctrl_if.slave  bus
);

  ram_state_t        r_state;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic              w_req_fire;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Clear request in the same cycle blocks acceptance so it wins over req_valid.
  assign bus.req_ready = (r_state == IDLE) && !bus.clr_start;
  assign w_req_fire    = bus.req_valid && bus.req_ready;

  // Write port is shared between accepted writes and the clear counter.
  assign w_we    = (w_req_fire && bus.req_we) || (r_state == CLEAR);
  assign w_waddr = (r_state == CLEAR) ? r_cnt : bus.req_addr;
  assign w_wdata = (r_state == CLEAR) ? '0    : bus.req_wdata;

  ram_array u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (r_state == RD),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rsp_valid <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.clr_start) begin
            r_cnt   <= '0;
            r_state <= CLEAR;
          end else if (bus.req_valid && !bus.req_we) begin
            r_addr  <= bus.req_addr;
            r_state <= RD;
          end
        end
        RD: begin
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = w_rdata;
  assign bus.clr_busy  = (r_state == CLEAR);

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed self-checking bench for ram_port_ctrl.
module tb_ram_port_ctrl;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt;

  ram_port_ctrl_if bus ();

  ram_port_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  // Full read with rsp_ready high: checks accept, 2-cycle latency and return to IDLE.
  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    #1;
    check({tag, "_acc_rdy"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check({tag, "_rd_rdy"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rd_vld"}, 32'(bus.rsp_valid), 32'd0);
    tick();
    check({tag, "_rsp_rdy"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_vld"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_rsp_data"}, 32'(bus.rsp_rdata), 32'(exp));
    tick();
    check({tag, "_done_vld"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_done_rdy"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.clr_start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_clr_busy",  32'(bus.clr_busy),  32'd0);
    tick();

    // Basic write then read-back of the same address on the next edge.
    do_write(9'h003, 9'h1A5);
    do_read("t1", 9'h003, 9'h1A5);

    // Back-to-back writes, one per cycle, then read each.
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 9'(i);
      bus.req_wdata = 9'(9'h100 + i);
      #1;
      check($sformatf("t2_wr%0d_rdy", i), 32'(bus.req_ready), 32'd1);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("t2_rd%0d", i), 9'(i), 9'(9'h100 + i));
    end

    // Response stall: data must hold while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h003;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_stall%0d_vld", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("t3_stall%0d_data", i), 32'(bus.rsp_rdata), 32'h103);
      check($sformatf("t3_stall%0d_rdy", i), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("t3_after_vld", 32'(bus.rsp_valid), 32'd0);
    check("t3_after_rdy", 32'(bus.req_ready), 32'd1);
    check("t3_hold_data", 32'(bus.rsp_rdata), 32'h103);

    // Clear beats a simultaneous write request and lasts exactly DEPTH cycles.
    do_write(9'h000, 9'h1FF);
    do_write(9'h1FF, 9'h1FF);
    bus.clr_start = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 9'h005;
    bus.req_wdata = 9'h077;
    #1;
    check("t4_clr_blocks_rdy", 32'(bus.req_ready), 32'd0);
    tick();
    bus.clr_start = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 600 && bus.clr_busy; i++) begin
      busy_cnt++;
      tick();
    end
    check("t4_busy_cycles", 32'(busy_cnt), 32'd512);
    check("t4_rdy_after", 32'(bus.req_ready), 32'd1);
    do_read("t4_rd0",   9'h000, 9'h000);
    do_read("t4_rd255", 9'h0FF, 9'h000);
    do_read("t4_rd511", 9'h1FF, 9'h000);

    // Reset in cycle 100 of a clear leaves the sweep partial.
    do_write(9'h063, 9'h0AA);
    do_write(9'h1FF, 9'h1FF);
    do_read("t5_pre", 9'h1FF, 9'h1FF);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("t5_busy", 32'(bus.clr_busy), 32'd1);
    repeat (99) tick();
    rst = 1'b0;
    #1;
    check("t5_rst_busy",  32'(bus.clr_busy),  32'd0);
    check("t5_rst_vld",   32'(bus.rsp_valid), 32'd0);
    check("t5_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("t5_rst_rdy",   32'(bus.req_ready), 32'd1);
    #2;
    rst = 1'b1;
    tick();
    do_read("t5_rd0",   9'h000, 9'h000);
    do_read("t5_rd98",  9'h062, 9'h000);
    do_read("t5_rd99",  9'h063, 9'h0AA);
    do_read("t5_rd511", 9'h1FF, 9'h1FF);

    // clr_start during RESP is ignored and not remembered.
    do_write(9'h032, 9'h055);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h032;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.clr_start = 1'b1;
    #1;
    check("t6_rdy_resp", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_busy%0d", i), 32'(bus.clr_busy), 32'd0);
      check($sformatf("t6_vld%0d", i), 32'(bus.rsp_valid), 32'd1);
    end
    bus.clr_start = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    check("t6_done_vld",  32'(bus.rsp_valid), 32'd0);
    check("t6_done_busy", 32'(bus.clr_busy),  32'd0);
    check("t6_done_rdy",  32'(bus.req_ready), 32'd1);
    tick();
    check("t6_idle_busy", 32'(bus.clr_busy), 32'd0);
    do_read("t6_rd50",  9'h032, 9'h055);
    do_read("t6_rd511", 9'h1FF, 9'h1FF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
